step_gen: RTL and testbench
===========================

STEP_GEN -- requirements
Module: step_gen

Interface
REQ-001 SHALL have parameter SPEED_BITS, default 64: width of the signed speed inputs.
REQ-002 SHALL have parameter STEP_BIT, default 32: accumulator bit whose transition represents one motor step.
REQ-003 SHALL have parameter PULSE_LEN, default 8: step pulse high time, in clk cycles.
REQ-004 SHALL have parameter DIR_SETUP, default 4: delay in clk cycles from a dir change to the following step rising edge.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on posedge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port tick, input, 1: integration strobe, one cycle wide.
REQ-008 SHALL have ports speed_0..speed_7, input, SPEED_BITS signed each: per-channel speed, taken from the profile generator outputs.
REQ-009 SHALL have port enable, input, 8: per-channel step enable.
REQ-010 SHALL have port err_clr, input, 8: clears the matching step_err bits.
REQ-011 SHALL have port busy, output, 1: channel sweep in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when a sweep completes.
REQ-013 SHALL have port step, output, 8: per-channel step pulses.
REQ-014 SHALL have port dir, output, 8: per-channel direction, 1 = positive.
REQ-015 SHALL have port step_err, output, 8: sticky flag per channel, set when a step is dropped.
REQ-016 SHALL have port overrun, output, 1: sticky flag, set when a tick is ignored; cleared only by rst.
REQ-017 SHALL have port pos_sel, input, 3: position readback channel select.
REQ-018 SHALL have port pos_out, output, 32 signed: registered position of the pos_sel channel, valid one cycle after pos_sel.

Function
REQ-019 SHALL run a sequencer with two states, IDLE and SWEEP; the channel counter ch is 3 bits wide.
REQ-020 SHALL, in IDLE with tick=1, set busy=1, set ch=0 and enter SWEEP on the next edge.
REQ-021 SHALL process exactly one channel per cycle in SWEEP, in order 0..7, using one shared 64-bit adder.
REQ-022 SHALL, after processing ch=7, return to IDLE, clear busy and assert done for one cycle; tick-to-done latency is exactly 9 cycles.
REQ-023 SHALL, on tick while busy=1, ignore the tick and set overrun.
REQ-024 SHALL, when processing a channel, sign-extend speed to 64 bits and saturate it to ±(2^STEP_BIT−1) to give s.
REQ-025 SHALL compute acc_new = acc[ch] + s, wrapping modulo 2^64, and write acc_new back regardless of enable.
REQ-026 SHALL raise a step request when acc_new[STEP_BIT] != acc[ch][STEP_BIT] and enable[ch]=1; at most one request per channel per sweep.
REQ-027 SHALL set the requested direction to 1 if s>0 and to 0 if s<0; s=0 produces no request.
REQ-028 SHALL, on a request, update pos[ch] by ±1 (32-bit wrap), even if the pulse is dropped.
REQ-029 SHALL give each channel a countdown timer and a phase: IDLE_P, SETUP, or PULSE.
REQ-030 SHALL handle a request in channel phase IDLE_P as follows:
- If dir[ch] differs from the requested direction: update dir the next cycle, enter SETUP for DIR_SETUP cycles, then PULSE.
- Otherwise: step[ch] rises the next cycle (PULSE).
REQ-031 SHALL hold step[ch] high for exactly PULSE_LEN cycles, then return the channel to IDLE_P.
REQ-032 SHALL, on a request while the channel is in SETUP or PULSE, drop the pulse, leave dir unchanged and set step_err[ch].
REQ-033 SHALL give err_clr priority below a same-cycle step_err set, so the bit stays 1.
REQ-034 SHALL not let enable[ch]=0 abort a pulse already in progress.

Reset
REQ-035 SHALL, on rst, asynchronously clear the following to 0: acc[], pos[], timers, phases, state, ch, busy, done, step, dir, step_err, overrun, pos_out.
REQ-036 SHALL, on rst asserted mid-sweep or mid-pulse, drop step low immediately and discard any pending sweep.

Verification
REQ-037 SHALL be verified with speed_0=2^30, enable=0x01, 4 ticks spaced 20 cycles -> exactly one step[0] pulse, 8 cycles high, dir[0]=1, pos_out(sel 0)=1.
REQ-038 SHALL be verified with speed_3=−2^31 after pos_3 reached +1 -> dir[3] falls, step[3] rises 4 cycles later, pos_3 returns to 0.
REQ-039 SHALL be verified with a tick issued on the cycle after a first tick -> overrun=1, and done pulses exactly once, 9 cycles after the first tick.
REQ-040 SHALL be verified with speed_5=2^40 -> saturated to 2^32−1; one step per tick; ticks 2 cycles apart -> step_err[5]=1, while pos_5 still increments on every tick.
REQ-041 SHALL be verified with enable[2]=0 and speed_2=2^31 for 2 ticks, then enable[2]=1 -> no step while disabled; acc keeps integrating.
REQ-042 SHALL be verified with rst asserted during the 3rd cycle of a pulse -> step=0 within the same cycle, and all outputs 0.

Source files
------------

// File: rtl/step_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_gen
// Description : Eight-channel step/direction generator. A tick walks channels
//               0..7 through one shared 64-bit accumulator adder.
// Revision    : 1.0 - initial release
// ============================================================================
module step_gen #(
    parameter int SPEED_BITS = 64,
    parameter int STEP_BIT   = 32,
    parameter int PULSE_LEN  = 8,
    parameter int DIR_SETUP  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic signed [SPEED_BITS-1:0] speed_0,
    input  logic signed [SPEED_BITS-1:0] speed_1,
    input  logic signed [SPEED_BITS-1:0] speed_2,
    input  logic signed [SPEED_BITS-1:0] speed_3,
    input  logic signed [SPEED_BITS-1:0] speed_4,
    input  logic signed [SPEED_BITS-1:0] speed_5,
    input  logic signed [SPEED_BITS-1:0] speed_6,
    input  logic signed [SPEED_BITS-1:0] speed_7,
    input  logic [7:0]                   enable,
    input  logic [7:0]                   err_clr,
    input  logic [2:0]                   pos_sel,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   step,
    output logic [7:0]                   dir,
    output logic [7:0]                   step_err,
    output logic                         overrun,
    output logic signed [31:0]           pos_out
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_sweep = 1'b1;

    localparam logic [1:0] c_ph_idle  = 2'd0;
    localparam logic [1:0] c_ph_setup = 2'd1;
    localparam logic [1:0] c_ph_pulse = 2'd2;

    localparam int c_tmax = (PULSE_LEN > DIR_SETUP) ? PULSE_LEN : DIR_SETUP;
    localparam int c_tw   = $clog2(c_tmax + 1);

    localparam logic signed [63:0] c_sat_max = (64'sd1 <<< STEP_BIT) - 64'sd1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [2:0]          r_ch;
    logic                r_done;
    logic                r_overrun;
    logic                w_proc;
    logic                w_last;
    logic                w_ovr_set;

    logic [63:0]         r_acc   [8];
    logic signed [31:0]  r_pos   [8];
    logic [1:0]          r_phase [8];
    logic [c_tw-1:0]     r_timer [8];
    logic [7:0]          r_step;
    logic [7:0]          r_dir;
    logic [7:0]          r_step_err;
    logic signed [31:0]  r_pos_out;

    logic signed [SPEED_BITS-1:0] w_spd;
    logic signed [63:0]  w_spd_ext;
    logic signed [63:0]  w_s;
    logic [63:0]         w_acc_old;
    logic [63:0]         w_acc_new;
    logic                w_req;
    logic                w_req_dir;
    logic [7:0]          w_hit;

    // ---------------------------------------------------------------- sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (tick) w_state_nxt = c_st_sweep;
            c_st_sweep: if (r_ch == 3'd7) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_proc    = (r_state == c_st_sweep);
        w_last    = w_proc && (r_ch == 3'd7);
        w_ovr_set = w_proc && tick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch      <= 3'd0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= w_last;
            r_overrun <= r_overrun | w_ovr_set;
            if (w_proc) begin
                r_ch <= r_ch + 3'd1;
            end else if (tick) begin
                r_ch <= 3'd0;
            end
        end
    end

    // ----------------------------------------------------- shared datapath
    always_comb begin
        w_spd = speed_0;
        case (r_ch)
            3'd1:    w_spd = speed_1;
            3'd2:    w_spd = speed_2;
            3'd3:    w_spd = speed_3;
            3'd4:    w_spd = speed_4;
            3'd5:    w_spd = speed_5;
            3'd6:    w_spd = speed_6;
            3'd7:    w_spd = speed_7;
            default: w_spd = speed_0;
        endcase
    end

    assign w_spd_ext = 64'(w_spd);

    // Saturation keeps |s| below one step period, so bit STEP_BIT can toggle
    // at most once per sweep.
    always_comb begin
        if (w_spd_ext > c_sat_max) begin
            w_s = c_sat_max;
        end else if (w_spd_ext < -c_sat_max) begin
            w_s = -c_sat_max;
        end else begin
            w_s = w_spd_ext;
        end
        w_acc_old = r_acc[r_ch];
        w_acc_new = w_acc_old + w_s;
        w_req     = w_proc && enable[r_ch] && (w_s != 64'sd0) &&
                    (w_acc_new[STEP_BIT] != w_acc_old[STEP_BIT]);
        w_req_dir = ~w_s[63];
        for (int i = 0; i < 8; i++) begin
            w_hit[i] = w_req && (r_ch == 3'(i));
        end
    end

    // ------------------------------------------------------ channel state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_acc[i]   <= '0;
                r_pos[i]   <= '0;
                r_phase[i] <= c_ph_idle;
                r_timer[i] <= '0;
            end
            r_step     <= '0;
            r_dir      <= '0;
            r_step_err <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_proc && (r_ch == 3'(i))) begin
                    r_acc[i] <= w_acc_new;
                end
                if (w_hit[i]) begin
                    r_pos[i] <= w_req_dir ? r_pos[i] + 32'sd1 : r_pos[i] - 32'sd1;
                end

                case (r_phase[i])
                    c_ph_idle: begin
                        if (w_hit[i]) begin
                            r_dir[i] <= w_req_dir;
                            if ((w_req_dir != r_dir[i]) && (DIR_SETUP != 0)) begin
                                r_phase[i] <= c_ph_setup;
                                r_timer[i] <= c_tw'(DIR_SETUP - 1);
                            end else begin
                                r_phase[i] <= c_ph_pulse;
                                r_step[i]  <= 1'b1;
                                r_timer[i] <= c_tw'(PULSE_LEN - 1);
                            end
                        end
                    end
                    c_ph_setup: begin
                        if (r_timer[i] == '0) begin
                            r_phase[i] <= c_ph_pulse;
                            r_step[i]  <= 1'b1;
                            r_timer[i] <= c_tw'(PULSE_LEN - 1);
                        end else begin
                            r_timer[i] <= r_timer[i] - 1'b1;
                        end
                    end
                    c_ph_pulse: begin
                        if (r_timer[i] == '0) begin
                            r_phase[i] <= c_ph_idle;
                            r_step[i]  <= 1'b0;
                        end else begin
                            r_timer[i] <= r_timer[i] - 1'b1;
                        end
                    end
                    default: begin
                        r_phase[i] <= c_ph_idle;
                        r_step[i]  <= 1'b0;
                    end
                endcase

                // A new drop outranks a same-cycle clear.
                if (w_hit[i] && (r_phase[i] != c_ph_idle)) begin
                    r_step_err[i] <= 1'b1;
                end else if (err_clr[i]) begin
                    r_step_err[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos_out <= '0;
        end else begin
            r_pos_out <= r_pos[pos_sel];
        end
    end

    assign busy     = (r_state == c_st_sweep);
    assign done     = r_done;
    assign step     = r_step;
    assign dir      = r_dir;
    assign step_err = r_step_err;
    assign overrun  = r_overrun;
    assign pos_out  = r_pos_out;

endmodule
`default_nettype wire

// File: tb/tb_step_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_gen
// Description : Scoreboard bench for step_gen with a schedule-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_gen;

    localparam int DS = 4;
    localparam int PL = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               tick;
    logic signed [63:0] speed [8];
    logic [7:0]         enable;
    logic [7:0]         err_clr;
    logic [2:0]         pos_sel;
    logic               busy;
    logic               done;
    logic [7:0]         step;
    logic [7:0]         dir;
    logic [7:0]         step_err;
    logic               overrun;
    logic signed [31:0] pos_out;

    step_gen dut (
        .clk(clk), .rst(rst), .tick(tick),
        .speed_0(speed[0]), .speed_1(speed[1]), .speed_2(speed[2]), .speed_3(speed[3]),
        .speed_4(speed[4]), .speed_5(speed[5]), .speed_6(speed[6]), .speed_7(speed[7]),
        .enable(enable), .err_clr(err_clr), .pos_sel(pos_sel),
        .busy(busy), .done(done), .step(step), .dir(dir),
        .step_err(step_err), .overrun(overrun), .pos_out(pos_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: accumulators, positions and a per-channel busy horizon.
    typedef struct { int ch; int rise; int fall; bit d; bit dchg; } ev_t;
    typedef struct { int cyc; bit [7:0] err; bit ovr; bit [7:0] d; } dn_t;

    ev_t         evq [$];
    dn_t         dnq [$];
    logic [63:0] m_acc [8];
    int          m_pos [8];
    int          m_busy_end [8];
    bit [7:0]    m_dir;
    bit [7:0]    m_err;
    bit          m_ovr;
    int          m_sweep_end;

    task automatic model_reset();
        for (int c = 0; c < 8; c++) begin
            m_acc[c] = '0; m_pos[c] = 0; m_busy_end[c] = -1;
        end
        m_dir = '0; m_err = '0; m_ovr = 1'b0; m_sweep_end = -100;
        evq.delete(); dnq.delete();
    endtask

    function automatic logic signed [63:0] sat(input logic signed [63:0] v);
        logic signed [63:0] m;
        m = 64'sh0000_0000_FFFF_FFFF;
        if (v > m) return m;
        if (v < -m) return -m;
        return v;
    endfunction

    function automatic logic signed [63:0] rnd_speed();
        logic signed [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'sd0;
            1:       v = 64'sd1 <<< 30;
            2:       v = (64'sd1 <<< 31) + 64'($urandom_range(0, 1000));
            3:       v = {$urandom, $urandom};
            4:       v = 64'sd1 <<< 40;
            default: v = 64'(signed'($urandom));
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    task automatic tstep();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        while (cyc < m_sweep_end) tstep();
    endtask

    // Channel c of a sweep accepted at edge t is integrated at edge t+1+c.
    task automatic issue_tick();
        int t; int p; int rise;
        logic signed [63:0] s;
        logic [63:0] nw;
        bit rd; bit dchg;
        dn_t r;
        tick = 1'b1;
        t = cyc + 1;
        if (t <= m_sweep_end) begin
            m_ovr = 1'b1;
            if (dnq.size() > 0) begin
                r = dnq.pop_back();
                r.ovr = 1'b1;
                dnq.push_back(r);
            end
            tstep();
            tick = 1'b0;
        end else begin
            for (int c = 0; c < 8; c++) begin
                p  = t + 1 + c;
                s  = sat(speed[c]);
                nw = m_acc[c] + s;
                if (enable[c] && (nw[32] != m_acc[c][32])) begin
                    rd = (s > 0);
                    m_pos[c] = rd ? m_pos[c] + 1 : m_pos[c] - 1;
                    if (p <= m_busy_end[c]) begin
                        m_err[c] = 1'b1;
                    end else begin
                        dchg = (rd != m_dir[c]);
                        m_dir[c] = rd;
                        rise = dchg ? p + DS : p;
                        m_busy_end[c] = rise + PL;
                        evq.push_back('{c, rise, rise + PL, rd, dchg});
                    end
                end
                m_acc[c] = nw;
            end
            r.cyc = t + 8; r.err = m_err; r.ovr = m_ovr; r.d = m_dir;
            dnq.push_back(r);
            m_sweep_end = t + 8;
            tstep();
            tick = 1'b0;
            chk("busy_after_tick", busy, 1);
        end
    endtask

    task automatic readback(input int c);
        pos_sel = 3'(c);
        tstep();
        chk($sformatf("pos_out[%0d]", c), pos_out, longint'(32'(m_pos[c])) - ((m_pos[c] < 0) ? 0 : 0));
    endtask

    // Monitor: checks every step edge and every done pulse against the queues.
    bit [7:0] pstep;
    bit [7:0] pdir;
    int       dchg_cyc [8];
    int       mi;
    dn_t      md;

    always @(negedge clk) begin
        if (rst) begin
            pstep = step;
            pdir  = dir;
        end else begin
            for (int c = 0; c < 8; c++) begin
                if (dir[c] != pdir[c]) dchg_cyc[c] = cyc;
                if (step[c] != pstep[c]) begin
                    mi = -1;
                    foreach (evq[k]) if (mi < 0 && evq[k].ch == c) mi = k;
                    if (mi < 0) begin
                        chk("unexpected_step_edge_ch", c, -1);
                    end else if (step[c]) begin
                        chk($sformatf("rise_cycle[%0d]", c), cyc, evq[mi].rise);
                        chk($sformatf("dir_at_rise[%0d]", c), dir[c], evq[mi].d);
                        if (evq[mi].dchg)
                            chk($sformatf("dir_setup[%0d]", c), cyc - dchg_cyc[c], DS);
                    end else begin
                        chk($sformatf("fall_cycle[%0d]", c), cyc, evq[mi].fall);
                        evq.delete(mi);
                    end
                end
            end
            if (done) begin
                if (dnq.size() == 0) begin
                    chk("done_unexpected", cyc, -1);
                end else begin
                    md = dnq.pop_front();
                    chk("done_cycle", cyc, md.cyc);
                    chk("step_err_at_done", step_err, md.err);
                    chk("overrun_at_done", overrun, md.ovr);
                    chk("dir_at_done", dir, md.d);
                    chk("busy_at_done", busy, 0);
                end
            end
            pstep = step;
            pdir  = dir;
        end
    end

    initial begin
        int mx; int tries; ev_t e;
        rst = 1'b1; tick = 1'b0; enable = '0; err_clr = '0; pos_sel = '0;
        for (int c = 0; c < 8; c++) speed[c] = '0;
        model_reset();
        repeat (3) tstep();
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_pos_out", pos_out, 0);
        rst = 1'b0;
        repeat (2) tstep();

        // Slow integration: one pulse after four ticks.
        speed[0] = 64'sd1 <<< 30; enable = 8'h01;
        repeat (4) begin issue_tick(); repeat (19) tstep(); end
        readback(0);
        chk("pos0_after_4_ticks", pos_out, 1);

        // Direction reversal on channel 3.
        speed[0] = '0; enable = 8'h08; speed[3] = 64'sd1 <<< 31;
        repeat (2) begin issue_tick(); repeat (19) tstep(); end
        readback(3);
        speed[3] = -(64'sd1 <<< 31);
        issue_tick(); repeat (19) tstep();
        readback(3);
        chk("pos3_back_to_zero", pos_out, 0);

        // Tick while busy.
        speed[3] = '0;
        issue_tick(); issue_tick();
        wait_idle(); tstep();
        chk("overrun_sticky", overrun, 1);

        // Saturated fast channel with back-to-back sweeps.
        enable = 8'h20; speed[5] = 64'sd1 <<< 40;
        repeat (4) begin wait_idle(); issue_tick(); end
        wait_idle(); repeat (14) tstep();
        chk("step_err5", step_err[5], 1);
        readback(5);

        // Disabled channel keeps integrating.
        speed[5] = '0; enable = 8'h00; speed[2] = 64'sd1 <<< 31;
        repeat (2) begin issue_tick(); repeat (19) tstep(); end
        enable = 8'h04;
        repeat (2) begin issue_tick(); repeat (19) tstep(); end
        readback(2);
        chk("pos2_after_enable", pos_out, 1);

        // Error clear.
        wait_idle(); err_clr = 8'hFF; tstep(); err_clr = '0; m_err = '0;
        chk("step_err_cleared", step_err, 0);

        // Randomised phase.
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            for (int c = 0; c < 8; c++) speed[c] = rnd_speed();
            enable = 8'($urandom);
            issue_tick();
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 6)) tstep();
                issue_tick();
            end
            wait_idle();
            repeat ($urandom_range(1, 20)) tstep();
        end
        wait_idle(); repeat (20) tstep();
        for (int c = 0; c < 8; c++) readback(c);
        chk("final_step_err", step_err, m_err);
        chk("pending_steps", evq.size(), 0);
        chk("pending_done", dnq.size(), 0);

        // Reset during the third high cycle of a pulse.
        for (int c = 0; c < 8; c++) speed[c] = 64'sh0000_0000_FFFF_FFFF;
        enable = 8'hFF;
        tries = 0;
        while (evq.size() == 0 && tries < 6) begin
            wait_idle();
            mx = 0;
            for (int c = 0; c < 8; c++) if (m_busy_end[c] > mx) mx = m_busy_end[c];
            while (cyc <= mx) tstep();
            issue_tick();
            tries++;
        end
        chk("rst_test_has_pulse", evq.size() > 0, 1);
        if (evq.size() > 0) begin
            e = evq[0];
            while (cyc < e.rise + 2) tstep();
            chk("step_high_before_rst", step[e.ch], 1);
            #2 rst = 1'b1;
            #1;
            chk("rst_mid_pulse_step", step, 0);
            chk("rst_mid_pulse_dir", dir, 0);
            chk("rst_mid_pulse_busy", busy, 0);
            chk("rst_mid_pulse_err", step_err, 0);
            chk("rst_mid_pulse_ovr", overrun, 0);
            chk("rst_mid_pulse_pos_out", pos_out, 0);
            model_reset();
            repeat (2) tstep();
            rst = 1'b0;
            readback(e.ch);
            chk("done_after_rst", done, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
